// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard and forwarding controller for the two-line (ALU + MEM) EX stage.
// Shadows the destinations held in EX/MEM (p3) and MEM/WB (p4), picks forwarding sources,
// sequences load-use stalls and redirect flushes, and keeps saturating stall/flush counters.
module ex_hazard_ctrl #(
   parameter int unsigned REDIRECT_LAT = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p2_valid,
   input  logic             p2_alu_regWrite,
   input  logic             p2_mem_regWrite,
   input  logic             p2_memWrite,
   input  logic             p2_aluSrcB,
   input  logic             p2_isBranch,
   input  logic             p2_isJump,
   input  logic             branch_taken,
   input  logic [2:0]       p2_alu_rn,
   input  logic [2:0]       p2_alu_rm,
   input  logic [2:0]       p2_alu_rd,
   input  logic [2:0]       p2_mem_rn,
   input  logic [2:0]       p2_mem_rd,
   output logic [1:0]       f_alu_reg_rn_sel,
   output logic [1:0]       f_alu_reg_rm_sel,
   output logic [1:0]       f_mem_reg_rn_sel,
   output logic             f_mem_reg_rd_sel,
   output logic             p1_pipeline_regWrite,
   output logic             pc_write,
   output logic             p2_pipeline_regWrite,
   output logic             p3_pipeline_regWrite,
   output logic             IF_flush,
   output logic             ID_flush,
   output logic             EX_flush,
   output logic             wr_conflict,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      REDIR   = 2'd2
   } state_t;

   // Counter preload: a redirect always flushes one cycle in RUN, the rest in REDIR.
   localparam logic [2:0] REDIR_INIT = 3'(REDIRECT_LAT - 1);

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             p3_alu_we_q, p3_alu_we_d, p3_ld_we_q, p3_ld_we_d;
   logic [2:0]       p3_alu_rd_q, p3_alu_rd_d, p3_mem_rd_q, p3_mem_rd_d;
   logic             p4_alu_we_q, p4_alu_we_d, p4_ld_we_q, p4_ld_we_d;
   logic [2:0]       p4_alu_rd_q, p4_alu_rd_d, p4_mem_rd_q, p4_mem_rd_d;
   logic             wr_conflict_q, wr_conflict_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic       rm_read_s, mrd_read_s, ld_hz_s, redirect_s, conflict_s, stall_fire_s;
   logic [1:0] rn_sel_s, rm_sel_s, mrn_sel_s;
   logic       mrd_sel_s;
   logic       pc_en_s, p1_en_s, p2_en_s, p3_en_s, if_fl_s, id_fl_s, ex_fl_s;

   function automatic logic hit(input logic we, input logic [2:0] rd, input logic [2:0] src);
      return we && (rd == src);
   endfunction

   // Priority: youngest ALU result, then the load in WB, then the older ALU result in WB.
   function automatic logic [1:0] fwd_sel(input logic rd_en, input logic [2:0] src,
                                          input logic a3we, input logic [2:0] a3rd,
                                          input logic l4we, input logic [2:0] l4rd,
                                          input logic a4we, input logic [2:0] a4rd);
      logic [1:0] sel;
      if (!rd_en)                   sel = 2'd0;
      else if (hit(a3we, a3rd, src)) sel = 2'd1;
      else if (hit(l4we, l4rd, src)) sel = 2'd3;
      else if (hit(a4we, a4rd, src)) sel = 2'd2;
      else                           sel = 2'd0;
      return sel;
   endfunction

   // Source usage, forwarding selects and load-use hazard detection.
   always_comb begin
      rm_read_s  = p2_valid & ~p2_aluSrcB;
      mrd_read_s = p2_valid & p2_memWrite;
      rn_sel_s   = fwd_sel(p2_valid, p2_alu_rn, p3_alu_we_q, p3_alu_rd_q,
                           p4_ld_we_q, p4_mem_rd_q, p4_alu_we_q, p4_alu_rd_q);
      rm_sel_s   = fwd_sel(rm_read_s, p2_alu_rm, p3_alu_we_q, p3_alu_rd_q,
                           p4_ld_we_q, p4_mem_rd_q, p4_alu_we_q, p4_alu_rd_q);
      mrn_sel_s  = fwd_sel(p2_valid, p2_mem_rn, p3_alu_we_q, p3_alu_rd_q,
                           p4_ld_we_q, p4_mem_rd_q, p4_alu_we_q, p4_alu_rd_q);
      // Store data has only a p3 ALU path; anything older waits one cycle for the regfile.
      mrd_sel_s  = mrd_read_s & hit(p3_alu_we_q, p3_alu_rd_q, p2_mem_rd);
      ld_hz_s    = (p2_valid   & hit(p3_ld_we_q, p3_mem_rd_q, p2_alu_rn))
                 | (rm_read_s  & hit(p3_ld_we_q, p3_mem_rd_q, p2_alu_rm))
                 | (p2_valid   & hit(p3_ld_we_q, p3_mem_rd_q, p2_mem_rn))
                 | (mrd_read_s & (hit(p3_ld_we_q, p3_mem_rd_q, p2_mem_rd)
                                | hit(p4_ld_we_q, p4_mem_rd_q, p2_mem_rd)
                                | hit(p4_alu_we_q, p4_alu_rd_q, p2_mem_rd)));
      redirect_s = p2_valid & (p2_isJump | (p2_isBranch & branch_taken));
      conflict_s = p2_valid & p2_alu_regWrite & p2_mem_regWrite & (p2_alu_rd == p2_mem_rd);
   end

   // Stall/redirect sequencer: next state and raw pipeline enables/flushes.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_en_s      = 1'b1;
      p1_en_s      = 1'b1;
      p2_en_s      = 1'b1;
      p3_en_s      = 1'b1;
      if_fl_s      = 1'b0;
      id_fl_s      = 1'b0;
      ex_fl_s      = 1'b0;
      stall_fire_s = 1'b0;
      case (state_q)
         RUN, LDSTALL: begin
            // LDSTALL ignores ld_hz so a held bundle never stalls twice.
            if ((state_q == RUN) && ld_hz_s) begin
               pc_en_s      = 1'b0;
               p1_en_s      = 1'b0;
               p2_en_s      = 1'b0;
               ex_fl_s      = 1'b1;
               stall_fire_s = 1'b1;
               state_d      = LDSTALL;
            end else if (redirect_s) begin
               if_fl_s = 1'b1;
               id_fl_s = 1'b1;
               cnt_d   = REDIR_INIT;
               if (REDIR_INIT != 3'd0) state_d = REDIR;
               else                    state_d = RUN;
            end else begin
               state_d = RUN;
            end
         end
         REDIR: begin
            if_fl_s = 1'b1;
            id_fl_s = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) state_d = RUN;
            else               state_d = REDIR;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Next shadow contents, sticky conflict flag and saturating counters.
   always_comb begin
      p3_alu_we_d = p3_alu_we_q;
      p3_ld_we_d  = p3_ld_we_q;
      p3_alu_rd_d = p3_alu_rd_q;
      p3_mem_rd_d = p3_mem_rd_q;
      if (p3_en_s) begin
         p3_alu_we_d = p2_valid & p2_alu_regWrite & ~ex_fl_s;
         // On a same-rd conflict only the ALU write is tracked.
         p3_ld_we_d  = p2_valid & p2_mem_regWrite & ~ex_fl_s & ~conflict_s;
         p3_alu_rd_d = p2_alu_rd;
         p3_mem_rd_d = p2_mem_rd;
      end else begin
         p3_alu_we_d = p3_alu_we_q;
      end
      p4_alu_we_d   = p3_alu_we_q;
      p4_ld_we_d    = p3_ld_we_q;
      p4_alu_rd_d   = p3_alu_rd_q;
      p4_mem_rd_d   = p3_mem_rd_q;
      wr_conflict_d = wr_conflict_q | conflict_s;
      if (stall_fire_s && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      else                                 stall_cnt_d = stall_cnt_q;
      if (if_fl_s && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
      else                            flush_cnt_d = flush_cnt_q;
   end

   // Output stage: reset forces the pipeline to free-run with no flushes or forwarding.
   always_comb begin
      if (!reset) begin
         f_alu_reg_rn_sel     = 2'd0;
         f_alu_reg_rm_sel     = 2'd0;
         f_mem_reg_rn_sel     = 2'd0;
         f_mem_reg_rd_sel     = 1'b0;
         pc_write             = 1'b1;
         p1_pipeline_regWrite = 1'b1;
         p2_pipeline_regWrite = 1'b1;
         p3_pipeline_regWrite = 1'b1;
         IF_flush             = 1'b0;
         ID_flush             = 1'b0;
         EX_flush             = 1'b0;
      end else begin
         f_alu_reg_rn_sel     = rn_sel_s;
         f_alu_reg_rm_sel     = rm_sel_s;
         f_mem_reg_rn_sel     = mrn_sel_s;
         f_mem_reg_rd_sel     = mrd_sel_s;
         pc_write             = pc_en_s;
         p1_pipeline_regWrite = p1_en_s;
         p2_pipeline_regWrite = p2_en_s;
         p3_pipeline_regWrite = p3_en_s;
         IF_flush             = if_fl_s;
         ID_flush             = id_fl_s;
         EX_flush             = ex_fl_s;
      end
      wr_conflict = wr_conflict_q;
      stall_cnt   = stall_cnt_q;
      flush_cnt   = flush_cnt_q;
   end

   // State, shadow and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= RUN;
         cnt_q         <= 3'd0;
         p3_alu_we_q   <= 1'b0;
         p3_ld_we_q    <= 1'b0;
         p3_alu_rd_q   <= 3'd0;
         p3_mem_rd_q   <= 3'd0;
         p4_alu_we_q   <= 1'b0;
         p4_ld_we_q    <= 1'b0;
         p4_alu_rd_q   <= 3'd0;
         p4_mem_rd_q   <= 3'd0;
         wr_conflict_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         p3_alu_we_q   <= p3_alu_we_d;
         p3_ld_we_q    <= p3_ld_we_d;
         p3_alu_rd_q   <= p3_alu_rd_d;
         p3_mem_rd_q   <= p3_mem_rd_d;
         p4_alu_we_q   <= p4_alu_we_d;
         p4_ld_we_q    <= p4_ld_we_d;
         p4_alu_rd_q   <= p4_alu_rd_d;
         p4_mem_rd_q   <= p4_mem_rd_d;
         wr_conflict_q <= wr_conflict_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed vectors with hand-computed expectations queued by the driver
// and checked by an independent negedge monitor.
module tb_ex_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        p2_valid, p2_alu_regWrite, p2_mem_regWrite, p2_memWrite, p2_aluSrcB;
   logic        p2_isBranch, p2_isJump, branch_taken;
   logic [2:0]  p2_alu_rn, p2_alu_rm, p2_alu_rd, p2_mem_rn, p2_mem_rd;
   logic [1:0]  f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel;
   logic        f_mem_reg_rd_sel, p1_pipeline_regWrite, pc_write;
   logic        p2_pipeline_regWrite, p3_pipeline_regWrite;
   logic        IF_flush, ID_flush, EX_flush, wr_conflict;
   logic [15:0] stall_cnt, flush_cnt;

   typedef struct packed {
      logic       v, aw, ld, st, srcb, br, tk;
      logic [2:0] ard, mrd, arn, arm, mrn;
   } vec_t;

   logic [46:0] exp_q[$];
   string       name_q[$];
   int          tests = 0;
   int          fails = 0;

   ex_hazard_ctrl #(.REDIRECT_LAT(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .p2_valid(p2_valid), .p2_alu_regWrite(p2_alu_regWrite),
      .p2_mem_regWrite(p2_mem_regWrite), .p2_memWrite(p2_memWrite),
      .p2_aluSrcB(p2_aluSrcB), .p2_isBranch(p2_isBranch), .p2_isJump(p2_isJump),
      .branch_taken(branch_taken),
      .p2_alu_rn(p2_alu_rn), .p2_alu_rm(p2_alu_rm), .p2_alu_rd(p2_alu_rd),
      .p2_mem_rn(p2_mem_rn), .p2_mem_rd(p2_mem_rd),
      .f_alu_reg_rn_sel(f_alu_reg_rn_sel), .f_alu_reg_rm_sel(f_alu_reg_rm_sel),
      .f_mem_reg_rn_sel(f_mem_reg_rn_sel), .f_mem_reg_rd_sel(f_mem_reg_rd_sel),
      .p1_pipeline_regWrite(p1_pipeline_regWrite), .pc_write(pc_write),
      .p2_pipeline_regWrite(p2_pipeline_regWrite), .p3_pipeline_regWrite(p3_pipeline_regWrite),
      .IF_flush(IF_flush), .ID_flush(ID_flush), .EX_flush(EX_flush),
      .wr_conflict(wr_conflict), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t bnd(input logic v, input logic aw, input logic [2:0] ard,
                                input logic ld, input logic [2:0] mrd, input logic st,
                                input logic srcb, input logic [2:0] arn, input logic [2:0] arm,
                                input logic [2:0] mrn, input logic br, input logic tk);
      vec_t r;
      r.v = v; r.aw = aw; r.ard = ard; r.ld = ld; r.mrd = mrd; r.st = st;
      r.srcb = srcb; r.arn = arn; r.arm = arm; r.mrn = mrn; r.br = br; r.tk = tk;
      return r;
   endfunction

   // Expected packing: {rn,rm,mrn,mrd_sel, {pc,p1,p2,p3}, {IF,ID,EX}, wr_conflict, stall, flush}
   function automatic logic [46:0] mk(input logic [1:0] rn, input logic [1:0] rm,
                                      input logic [1:0] mrn, input logic mrd,
                                      input logic [3:0] en, input logic [2:0] fl,
                                      input logic wrc, input logic [15:0] sc,
                                      input logic [15:0] fc);
      return {rn, rm, mrn, mrd, en, fl, wrc, sc, fc};
   endfunction

   task automatic go(input string nm, input logic rst, input vec_t b, input logic [46:0] e);
      @(posedge clk);
      #1;
      reset           = rst;
      p2_valid        = b.v;
      p2_alu_regWrite = b.aw;
      p2_mem_regWrite = b.ld;
      p2_memWrite     = b.st;
      p2_aluSrcB      = b.srcb;
      p2_isBranch     = b.br;
      p2_isJump       = 1'b0;
      branch_taken    = b.tk;
      p2_alu_rn       = b.arn;
      p2_alu_rm       = b.arm;
      p2_alu_rd       = b.ard;
      p2_mem_rn       = b.mrn;
      p2_mem_rd       = b.mrd;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: compares DUT outputs mid-cycle against the oldest queued expectation.
   always @(negedge clk) begin
      logic [46:0] act, e;
      string       nm;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel,
                pc_write, p1_pipeline_regWrite, p2_pipeline_regWrite, p3_pipeline_regWrite,
                IF_flush, ID_flush, EX_flush, wr_conflict, stall_cnt, flush_cnt};
         tests++;
         if (act !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
         end
      end
   end

   initial begin
      vec_t idle, ldr2, add3, br_tk, br5, st6;
      idle  = bnd(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      ldr2  = bnd(1'b1, 1'b0, 3'd7, 1'b1, 3'd2, 1'b0, 1'b1, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0);
      add3  = bnd(1'b1, 1'b1, 3'd3, 1'b0, 3'd7, 1'b0, 1'b0, 3'd2, 3'd4, 3'd7, 1'b0, 1'b0);
      br_tk = bnd(1'b1, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1);
      br5   = bnd(1'b1, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1, 3'd5, 3'd7, 3'd7, 1'b1, 1'b1);
      st6   = bnd(1'b1, 1'b0, 3'd7, 1'b0, 3'd6, 1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0);
      reset = 1'b0;
      p2_valid = 1'b0; p2_alu_regWrite = 1'b0; p2_mem_regWrite = 1'b0; p2_memWrite = 1'b0;
      p2_aluSrcB = 1'b0; p2_isBranch = 1'b0; p2_isJump = 1'b0; branch_taken = 1'b0;
      p2_alu_rn = 3'd0; p2_alu_rm = 3'd0; p2_alu_rd = 3'd0; p2_mem_rn = 3'd0; p2_mem_rd = 3'd0;

      go("reset_state", 1'b0, idle, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd0,16'd0));
      // ALU -> ALU forwarding from p3 then p4
      go("alu_w_r1", 1'b1, bnd(1'b1,1'b1,3'd1,1'b0,3'd7,1'b0,1'b1,3'd7,3'd7,3'd7,1'b0,1'b0),
         mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd0,16'd0));
      go("fwd_p3_alu", 1'b1, bnd(1'b1,1'b1,3'd4,1'b0,3'd7,1'b0,1'b1,3'd1,3'd7,3'd7,1'b0,1'b0),
         mk(2'd1,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd0,16'd0));
      go("fwd_p4_and_p3", 1'b1, bnd(1'b1,1'b0,3'd7,1'b0,3'd7,1'b0,1'b0,3'd1,3'd4,3'd7,1'b0,1'b0),
         mk(2'd2,2'd1,2'd0,1'b0,4'hF,3'b000,1'b0,16'd0,16'd0));
      // Load-use stall
      go("ldr_r2", 1'b1, ldr2, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd0,16'd0));
      go("ld_use_stall", 1'b1, add3, mk(2'd0,2'd0,2'd0,1'b0,4'h1,3'b001,1'b0,16'd0,16'd0));
      go("after_stall_sel3", 1'b1, add3, mk(2'd3,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd1,16'd0));
      go("idle_no_fwd", 1'b1, idle, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd1,16'd0));
      // Taken branch, two flush cycles; not-taken branch
      go("br_taken_c1", 1'b1, br_tk, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b110,1'b0,16'd1,16'd0));
      go("br_taken_c2", 1'b1, br_tk, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b110,1'b0,16'd1,16'd1));
      go("br_not_taken", 1'b1, bnd(1'b1,1'b0,3'd7,1'b0,3'd7,1'b0,1'b1,3'd7,3'd7,3'd7,1'b1,1'b0),
         mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd1,16'd2));
      // Load r5 followed by taken branch reading r5: stall wins
      go("ldr_r5", 1'b1, bnd(1'b1,1'b0,3'd7,1'b1,3'd5,1'b0,1'b1,3'd7,3'd7,3'd7,1'b0,1'b0),
         mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd1,16'd2));
      go("stall_over_br", 1'b1, br5, mk(2'd0,2'd0,2'd0,1'b0,4'h1,3'b001,1'b0,16'd1,16'd2));
      go("br_after_stall", 1'b1, br5, mk(2'd3,2'd0,2'd0,1'b0,4'hF,3'b110,1'b0,16'd2,16'd2));
      go("redir_tail", 1'b1, idle, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b110,1'b0,16'd2,16'd3));
      // Same-bundle write conflict
      go("conflict_issue", 1'b1, bnd(1'b1,1'b1,3'd3,1'b1,3'd3,1'b0,1'b1,3'd7,3'd7,3'd7,1'b0,1'b0),
         mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd2,16'd4));
      go("conflict_rd_alu", 1'b1, bnd(1'b1,1'b0,3'd7,1'b0,3'd7,1'b0,1'b1,3'd3,3'd7,3'd7,1'b0,1'b0),
         mk(2'd1,2'd0,2'd0,1'b0,4'hF,3'b000,1'b1,16'd2,16'd4));
      go("conflict_sticky", 1'b1, bnd(1'b1,1'b0,3'd7,1'b0,3'd7,1'b0,1'b1,3'd3,3'd7,3'd3,1'b0,1'b0),
         mk(2'd2,2'd0,2'd2,1'b0,4'hF,3'b000,1'b1,16'd2,16'd4));
      // Store-data forwarding and store-data stall
      go("alu_w_r6", 1'b1, bnd(1'b1,1'b1,3'd6,1'b0,3'd7,1'b0,1'b1,3'd7,3'd7,3'd7,1'b0,1'b0),
         mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b1,16'd2,16'd4));
      go("st_data_fwd_p3", 1'b1, st6, mk(2'd0,2'd0,2'd0,1'b1,4'hF,3'b000,1'b1,16'd2,16'd4));
      go("st_data_p4_stall", 1'b1, st6, mk(2'd0,2'd0,2'd0,1'b0,4'h1,3'b001,1'b1,16'd2,16'd4));
      // Reset dropped during LDSTALL
      go("reset_in_stall", 1'b0, st6, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b1,16'd3,16'd4));
      go("post_reset", 1'b1, idle, mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd0,16'd0));
      go("shadow_cleared", 1'b1, bnd(1'b1,1'b0,3'd7,1'b0,3'd7,1'b0,1'b1,3'd6,3'd7,3'd7,1'b0,1'b0),
         mk(2'd0,2'd0,2'd0,1'b0,4'hF,3'b000,1'b0,16'd0,16'd0));

      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
